// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// Optional build macro used by muldiv_unit: MULDIV_FAST_MULT_EN.
package muldiv_pkg;

  localparam int MULDIV_WIDTH = 32;

  typedef enum logic [1:0] {
    MULT  = 2'b00,
    MULTU = 2'b01,
    DIV   = 2'b10,
    DIVU  = 2'b11
  } muldiv_op_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    CALC = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add (multiply) or restoring
// compare-subtract-shift (divide) on a 2*WIDTH accumulator.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opnd_i,
  input  logic               is_div_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;

  always_comb begin
    // Multiply: {product_hi, multiplier} shifts right, carry enters at the top.
    sum    = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, (acc_i[0] ? opnd_i : '0)};
    // Divide: {remainder, dividend/quotient} shifts left one bit per step.
    rem_sh = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
    diff   = rem_sh[WIDTH-1:0] - opnd_i;
    if (is_div_i) begin
      if (rem_sh >= {1'b0, opnd_i}) acc_o = {diff, acc_i[WIDTH-2:0], 1'b1};
      else                          acc_o = {rem_sh[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
    end else begin
      acc_o = {sum, acc_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// HI/LO owning multiply/divide sequencer (MULT, MULTU, DIV, DIVU, MTHI/MTLO).
// Build macro MULDIV_FAST_MULT_EN: single-cycle multiplier for MULT/MULTU.
// Handshake: Start is accepted only in IDLE/DONE; Busy covers PREP..FIX;
// Done pulses for the single DONE cycle, when Hi/Lo hold the new result.
import muldiv_pkg::*;

module muldiv_unit #(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [1:0]        Op,
  input  logic [WIDTH-1:0]  A,
  input  logic [WIDTH-1:0]  B,
  input  logic              HiWrite,
  input  logic              LoWrite,
  input  logic [WIDTH-1:0]  WrData,
  output logic              Busy,
  output logic              Done,
  output logic              DivZero,
  output logic [WIDTH-1:0]  Hi,
  output logic [WIDTH-1:0]  Lo,
  output muldiv_state_t     dbg_state
);

  localparam int CW = $clog2(WIDTH);

  muldiv_state_t      state_q, state_d;
  muldiv_op_t         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, opnd_q, opnd_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, step_acc, prod;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
  logic               divzero_q, divzero_d, busy_q, busy_d, done_q, done_d;
  logic               is_div, is_signed;
  logic [WIDTH-1:0]   mag_a, mag_b, quo, rem;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc_i    (acc_q),
    .opnd_i   (opnd_q),
    .is_div_i (is_div),
    .acc_o    (step_acc)
  );

  always_comb begin
    state_d = state_q; op_d = op_q; a_d = a_q; b_d = b_q; opnd_d = opnd_q;
    hi_d = hi_q; lo_d = lo_q; acc_d = acc_q; cnt_d = cnt_q;
    neg_lo_d = neg_lo_q; neg_hi_d = neg_hi_q; divzero_d = divzero_q;
    is_div    = op_q[1];
    is_signed = ~op_q[0];
    mag_a = (is_signed && a_q[WIDTH-1]) ? -a_q : a_q;
    mag_b = (is_signed && b_q[WIDTH-1]) ? -b_q : b_q;
    quo   = acc_q[WIDTH-1:0];
    rem   = acc_q[2*WIDTH-1:WIDTH];
    prod  = neg_lo_q ? -acc_q : acc_q;
    case (state_q)
      IDLE, DONE: begin
        if (Start) begin
          op_d = muldiv_op_t'(Op); a_d = A; b_d = B;
          divzero_d = 1'b0;
          state_d = PREP;
        end else begin
          state_d = IDLE;
          if (HiWrite) hi_d = WrData;
          if (LoWrite) lo_d = WrData;
        end
      end
      PREP: begin
        neg_lo_d = is_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        neg_hi_d = is_signed & a_q[WIDTH-1];
        cnt_d    = CW'(WIDTH-1);
        if (is_div) begin
          acc_d = {{WIDTH{1'b0}}, mag_a}; opnd_d = mag_b;
        end else begin
          acc_d = {{WIDTH{1'b0}}, mag_b}; opnd_d = mag_a;
        end
        if (is_div && b_q == '0) begin
          divzero_d = 1'b1;
          state_d = FIX;
        end else begin
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = step_acc;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = FIX;
`ifdef MULDIV_FAST_MULT_EN
        if (!is_div) begin
          acc_d   = (2*WIDTH)'(acc_q[WIDTH-1:0]) * (2*WIDTH)'(opnd_q);
          cnt_d   = '0;
          state_d = FIX;
        end
`endif
      end
      FIX: begin
        if (divzero_q) begin
          hi_d = a_q; lo_d = '1;
        end else if (is_div) begin
          lo_d = neg_lo_q ? -quo : quo;
          hi_d = neg_hi_q ? -rem : rem;
        end else begin
          {hi_d, lo_d} = prod;
        end
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == PREP) || (state_d == CALC) || (state_d == FIX);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE; op_q <= MULT; a_q <= '0; b_q <= '0; opnd_q <= '0;
      hi_q <= '0; lo_q <= '0; acc_q <= '0; cnt_q <= '0;
      neg_lo_q <= 1'b0; neg_hi_q <= 1'b0; divzero_q <= 1'b0;
      busy_q <= 1'b0; done_q <= 1'b0;
    end else begin
      state_q <= state_d; op_q <= op_d; a_q <= a_d; b_q <= b_d; opnd_q <= opnd_d;
      hi_q <= hi_d; lo_q <= lo_d; acc_q <= acc_d; cnt_q <= cnt_d;
      neg_lo_q <= neg_lo_d; neg_hi_q <= neg_hi_d; divzero_q <= divzero_d;
      busy_q <= busy_d; done_q <= done_d;
    end
  end

  assign Busy      = busy_q;
  assign Done      = done_q;
  assign DivZero   = divzero_q;
  assign Hi        = hi_q;
  assign Lo        = lo_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vectors, randomized ops
// against an arithmetic reference model, Busy/Done timing, HI/LO writes, reset.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic          Clk, Reset, Start, HiWrite, LoWrite;
  logic [1:0]    Op;
  logic [W-1:0]  A, B, WrData, Hi, Lo;
  logic          Busy, Done, DivZero;
  muldiv_state_t dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [2*W-1:0] exp_q[$];

  muldiv_unit #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
    .HiWrite(HiWrite), .LoWrite(LoWrite), .WrData(WrData),
    .Busy(Busy), .Done(Done), .DivZero(DivZero), .Hi(Hi), .Lo(Lo),
    .dbg_state(dbg_state)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference: {hi, lo} from plain 64-bit arithmetic.
  function automatic logic [2*W-1:0] model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [63:0] sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = 64'(signed'(a)); sb = 64'(signed'(b));
    ua = {32'd0, a};      ub = {32'd0, b};
    if (op[1] && b == '0) return {a, 32'hFFFF_FFFF};
    case (op)
      2'b00: return sa * sb;
      2'b01: return ua * ub;
      2'b10: begin q = sa / sb; r = sa % sb; return {r[31:0], q[31:0]}; end
      default: begin q = ua / ub; r = ua % ub; return {r[31:0], q[31:0]}; end
    endcase
  endfunction

  function automatic int exp_lat(input logic [1:0] op, input logic [W-1:0] b);
    if (op[1] && b == '0) return 2;
`ifdef MULDIV_FAST_MULT_EN
    if (!op[1]) return 3;
`endif
    return W + 2;
  endfunction

  // Driver: called at a negedge; returns at the negedge where Done is seen.
  task automatic do_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int lat, output int busy_bad);
    Start = 1'b1; Op = op; A = a; B = b;
    @(posedge Clk);
    @(negedge Clk);
    Start = 1'b0;
    lat = 0; busy_bad = 0;
    while (!Done && lat < 200) begin
      if (!Busy) busy_bad++;
      @(posedge Clk); lat++;
      @(negedge Clk);
    end
  endtask

  task automatic test_reset();
    n_tests++; if (Busy !== 1'b0)   begin n_fail++; $display("FAIL reset_busy: got %b expected 0", Busy); end
    n_tests++; if (Done !== 1'b0)   begin n_fail++; $display("FAIL reset_done: got %b expected 0", Done); end
    n_tests++; if (DivZero !== 1'b0) begin n_fail++; $display("FAIL reset_divzero: got %b expected 0", DivZero); end
    n_tests++; if (Hi !== '0)       begin n_fail++; $display("FAIL reset_hi: got %h expected 0", Hi); end
    n_tests++; if (Lo !== '0)       begin n_fail++; $display("FAIL reset_lo: got %h expected 0", Lo); end
    n_tests++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE); end
  endtask

  task automatic test_directed();
    logic [1:0]  v_op[6]  = '{2'b01, 2'b00, 2'b11, 2'b10, 2'b10, 2'b00};
    logic [31:0] v_a[6]   = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFF9, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] v_b[6]   = '{32'hFFFF_FFFF, 32'd7, 32'd2, 32'd2, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [31:0] v_hi[6]  = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'h4000_0000};
    logic [31:0] v_lo[6]  = '{32'h0000_0001, 32'hFFFF_FFEB, 32'd3, 32'hFFFF_FFFD, 32'h8000_0000, 32'd0};
    int lat, bb;
    for (int i = 0; i < 6; i++) begin
      do_op(v_op[i], v_a[i], v_b[i], lat, bb);
      n_tests++; if (lat !== exp_lat(v_op[i], v_b[i])) begin n_fail++; $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, exp_lat(v_op[i], v_b[i])); end
      n_tests++; if (bb !== 0) begin n_fail++; $display("FAIL dir%0d_busy: got %0d low cycles expected 0", i, bb); end
      n_tests++; if (Hi !== v_hi[i]) begin n_fail++; $display("FAIL dir%0d_hi: got %h expected %h", i, Hi, v_hi[i]); end
      n_tests++; if (Lo !== v_lo[i]) begin n_fail++; $display("FAIL dir%0d_lo: got %h expected %h", i, Lo, v_lo[i]); end
      n_tests++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL dir%0d_busy_at_done: got %b expected 0", i, Busy); end
      @(negedge Clk);
      n_tests++; if (Done !== 1'b0) begin n_fail++; $display("FAIL dir%0d_done_width: got %b expected 0", i, Done); end
    end
  endtask

  task automatic test_divzero();
    int lat, bb, k;
    do_op(2'b10, 32'h1234, 32'd0, lat, bb);
    n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL dz_latency: got %0d expected 2", lat); end
    n_tests++; if (DivZero !== 1'b1) begin n_fail++; $display("FAIL dz_flag: got %b expected 1", DivZero); end
    n_tests++; if (Hi !== 32'h1234) begin n_fail++; $display("FAIL dz_hi: got %h expected 00001234", Hi); end
    n_tests++; if (Lo !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL dz_lo: got %h expected ffffffff", Lo); end
    repeat (3) @(negedge Clk);
    n_tests++; if (DivZero !== 1'b1) begin n_fail++; $display("FAIL dz_hold: got %b expected 1", DivZero); end
    Start = 1'b1; Op = 2'b11; A = 32'd7; B = 32'd2;
    @(posedge Clk);
    @(negedge Clk);
    Start = 1'b0;
    n_tests++; if (DivZero !== 1'b0) begin n_fail++; $display("FAIL dz_clear: got %b expected 0", DivZero); end
    k = 0;
    while (!Done && k < 200) begin @(negedge Clk); k++; end
    n_tests++; if (k >= 200) begin n_fail++; $display("FAIL dz_next_timeout: got %0d cycles expected < 200", k); end
    @(negedge Clk);
  endtask

  task automatic test_random();
    logic [1:0]     op;
    logic [W-1:0]   a, b;
    logic [2*W-1:0] exp;
    int lat, bb;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      case ($urandom_range(0, 6))
        0: b = '0;
        1: b = 32'd1;
        2: b = 32'hFFFF_FFFF;
        3: b = $urandom_range(1, 15);
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      exp_q.push_back(model(op, a, b));
      do_op(op, a, b, lat, bb);
      exp = exp_q.pop_front();
      n_tests++; if ({Hi, Lo} !== exp) begin n_fail++; $display("FAIL rnd%0d_result op=%0d a=%h b=%h: got %h expected %h", i, op, a, b, {Hi, Lo}, exp); end
      n_tests++; if (lat !== exp_lat(op, b)) begin n_fail++; $display("FAIL rnd%0d_latency: got %0d expected %0d", i, lat, exp_lat(op, b)); end
      n_tests++; if (DivZero !== (op[1] && b == '0)) begin n_fail++; $display("FAIL rnd%0d_divzero: got %b expected %b", i, DivZero, (op[1] && b == '0)); end
      n_tests++; if (bb !== 0) begin n_fail++; $display("FAIL rnd%0d_busy: got %0d low cycles expected 0", i, bb); end
      @(negedge Clk);
    end
  endtask

  task automatic test_busy_ignore();
    logic [2*W-1:0] exp;
    int lat;
    exp = model(2'b01, 32'h1234_5678, 32'h0000_9ABC);
    Start = 1'b1; Op = 2'b01; A = 32'h1234_5678; B = 32'h0000_9ABC;
    @(posedge Clk);
    @(negedge Clk);
    Start = 1'b0; lat = 0;
    repeat (5) begin @(posedge Clk); lat++; @(negedge Clk); end
    Start = 1'b1; Op = 2'b10; A = 32'd1; B = 32'd1; HiWrite = 1'b1; WrData = 32'hAAAA;
    @(posedge Clk); lat++;
    @(negedge Clk);
    Start = 1'b0; HiWrite = 1'b0;
    n_tests++; if (Hi === 32'hAAAA) begin n_fail++; $display("FAIL busy_hiwrite: got %h expected previous value", Hi); end
    while (!Done && lat < 200) begin @(posedge Clk); lat++; @(negedge Clk); end
    n_tests++; if (lat !== exp_lat(2'b01, 32'h9ABC)) begin n_fail++; $display("FAIL busy_latency: got %0d expected %0d", lat, exp_lat(2'b01, 32'h9ABC)); end
    n_tests++; if ({Hi, Lo} !== exp) begin n_fail++; $display("FAIL busy_result: got %h expected %h", {Hi, Lo}, exp); end
    @(negedge Clk);
  endtask

  task automatic test_hilo_write();
    int k;
    HiWrite = 1'b1; LoWrite = 1'b1; WrData = 32'h55;
    @(negedge Clk);
    HiWrite = 1'b0; LoWrite = 1'b0;
    n_tests++; if (Hi !== 32'h55 || Lo !== 32'h55) begin n_fail++; $display("FAIL wr_both: got %h/%h expected 00000055/00000055", Hi, Lo); end
    HiWrite = 1'b1; WrData = 32'h77;
    @(negedge Clk);
    HiWrite = 1'b0;
    n_tests++; if (Hi !== 32'h77 || Lo !== 32'h55) begin n_fail++; $display("FAIL wr_hi: got %h/%h expected 00000077/00000055", Hi, Lo); end
    Start = 1'b1; Op = 2'b01; A = 32'd3; B = 32'd5; LoWrite = 1'b1; WrData = 32'h99;
    @(negedge Clk);
    Start = 1'b0; LoWrite = 1'b0;
    n_tests++; if (Lo !== 32'h55) begin n_fail++; $display("FAIL wr_start_prio: got %h expected 00000055", Lo); end
    k = 0;
    while (!Done && k < 200) begin @(negedge Clk); k++; end
    n_tests++; if (Hi !== 32'd0 || Lo !== 32'd15) begin n_fail++; $display("FAIL wr_start_result: got %h/%h expected 00000000/0000000f", Hi, Lo); end
    @(negedge Clk);
  endtask

  task automatic test_back_to_back();
    int lat, bb;
    do_op(2'b11, 32'd100, 32'd7, lat, bb);
    n_tests++; if (Hi !== 32'd2 || Lo !== 32'd14) begin n_fail++; $display("FAIL b2b_first: got %h/%h expected 00000002/0000000e", Hi, Lo); end
    do_op(2'b00, 32'hFFFF_FFFE, 32'hFFFF_FFFB, lat, bb);
    n_tests++; if (lat !== exp_lat(2'b00, 32'hFFFF_FFFB)) begin n_fail++; $display("FAIL b2b_latency: got %0d expected %0d", lat, exp_lat(2'b00, 32'hFFFF_FFFB)); end
    n_tests++; if (Hi !== 32'd0 || Lo !== 32'd10) begin n_fail++; $display("FAIL b2b_second: got %h/%h expected 00000000/0000000a", Hi, Lo); end
    @(negedge Clk);
  endtask

  task automatic test_reset_mid();
    int done_cnt;
    HiWrite = 1'b1; LoWrite = 1'b1; WrData = 32'hCAFE;
    @(negedge Clk);
    HiWrite = 1'b0; LoWrite = 1'b0;
    Start = 1'b1; Op = 2'b01; A = 32'hDEAD_BEEF; B = 32'h1357_9BDF;
    @(posedge Clk);
    @(negedge Clk);
    Start = 1'b0;
    repeat (11) @(posedge Clk);
    #2 Reset = 1'b1;
    #1;
    n_tests++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b expected 0", Busy); end
    n_tests++; if (Done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_done: got %b expected 0", Done); end
    n_tests++; if (Hi !== '0 || Lo !== '0) begin n_fail++; $display("FAIL rst_mid_hilo: got %h/%h expected 0/0", Hi, Lo); end
    n_tests++; if (DivZero !== 1'b0) begin n_fail++; $display("FAIL rst_mid_divzero: got %b expected 0", DivZero); end
    @(negedge Clk);
    Reset = 1'b0;
    done_cnt = 0;
    repeat (40) begin @(negedge Clk); if (Done) done_cnt++; end
    n_tests++; if (done_cnt !== 0) begin n_fail++; $display("FAIL rst_mid_no_done: got %0d pulses expected 0", done_cnt); end
    n_tests++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL rst_mid_state: got %0d expected %0d", dbg_state, IDLE); end
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; Op = 2'b00; A = '0; B = '0;
    HiWrite = 1'b0; LoWrite = 1'b0; WrData = '0;
    repeat (3) @(negedge Clk);
    test_reset();
    Reset = 1'b0;
    @(negedge Clk);
    test_directed();
    test_divzero();
    test_random();
    test_busy_ignore();
    test_hilo_write();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
